// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operation request/response bundle for alu_pipe (valid/ready in, valid/ready out, flags).
interface alu_pipe_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
);
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   a_in;
  logic [DATA_WIDTH-1:0]   b_in;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   result_out;
  logic                    carry;
  logic                    zero;
  logic                    negative;
  logic                    busy;

  modport master (
    output in_valid, a_in, b_in, opcode, out_ready,
    input  in_ready, out_valid, result_out, carry, zero, negative, busy
  );

  modport slave (
    input  in_valid, a_in, b_in, opcode, out_ready,
    output in_ready, out_valid, result_out, carry, zero, negative, busy
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU, latency 1, result held until out_ready; a retiring result and a new op overlap with no bubble.
// ALU_PIPE_MUL_EN adds an iterative shift-add multiply on opcode 1110 (DATA_WIDTH+1 cycles, in_ready low while busy).
module alu_pipe #(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 4
) (
  input logic       clk,
  input logic       rst,
  alu_pipe_if.slave io
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [DATA_WIDTH:0] ONE_X = {{DATA_WIDTH{1'b0}}, 1'b1};
`ifdef ALU_PIPE_MUL_EN
  localparam logic [1:0] S_MUL = 2'd1;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
`endif

  typedef struct packed {
    logic                  carry;
    logic                  zero;
    logic                  negative;
    logic [DATA_WIDTH-1:0] value;
  } res_t;

  logic [1:0]          state;
  res_t                out_q;
  res_t                alu_res;
  logic                accept;
  logic [3:0]          op;
  logic [DATA_WIDTH:0] a_x;
  logic [DATA_WIDTH:0] b_x;
  logic [DATA_WIDTH:0] sum_x;

  // Opcodes with any bit set above bit 3 fall into the zero-result default.
  assign op  = ((io.opcode >> 4) == '0) ? io.opcode[3:0] : 4'hF;
  assign a_x = {1'b0, io.a_in};
  assign b_x = {1'b0, io.b_in};

  // Bit DATA_WIDTH of sum_x is the carry/borrow/shifted-out bit for every op.
  always_comb begin
    sum_x = '0;
    case (op)
      4'h0:    sum_x = a_x;
      4'h1:    sum_x = a_x + b_x;
      4'h2:    sum_x = a_x + b_x + ONE_X;
      4'h3:    sum_x = a_x - b_x;
      4'h4:    sum_x = a_x - b_x - ONE_X;
      4'h5:    sum_x = a_x + ONE_X;
      4'h6:    sum_x = a_x - ONE_X;
      4'h7:    sum_x = b_x;
      4'h8:    sum_x = a_x | b_x;
      4'h9:    sum_x = a_x ^ b_x;
      4'hA:    sum_x = a_x & b_x;
      4'hB:    sum_x = {1'b0, ~io.a_in};
      4'hC:    sum_x = {io.a_in, 1'b0};
      4'hD:    sum_x = {io.a_in[0], 1'b0, io.a_in[DATA_WIDTH-1:1]};
      default: sum_x = '0;
    endcase
    alu_res.carry    = sum_x[DATA_WIDTH];
    alu_res.value    = sum_x[DATA_WIDTH-1:0];
    alu_res.zero     = (sum_x[DATA_WIDTH-1:0] == '0);
    alu_res.negative = sum_x[DATA_WIDTH-1];
  end

`ifdef ALU_PIPE_MUL_EN
  logic [2*DATA_WIDTH-1:0] mcand;
  logic [2*DATA_WIDTH-1:0] prod;
  logic [2*DATA_WIDTH-1:0] prod_nxt;
  logic [DATA_WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]        cnt;
  logic                    is_mul;

  assign is_mul   = (op == 4'hE);
  assign prod_nxt = mplier[0] ? (prod + mcand) : prod;
`endif

  assign io.in_ready = (state == S_IDLE) | ((state == S_HOLD) & io.out_ready);
  assign accept      = io.in_valid & io.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      out_q <= '0;
`ifdef ALU_PIPE_MUL_EN
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_HOLD: begin
          if (accept) begin
`ifdef ALU_PIPE_MUL_EN
            if (is_mul) begin
              state  <= S_MUL;
              mcand  <= {{DATA_WIDTH{1'b0}}, io.a_in};
              mplier <= io.b_in;
              prod   <= '0;
              cnt    <= '0;
            end else
`endif
            begin
              out_q <= alu_res;
              state <= S_HOLD;
            end
          end else if ((state == S_HOLD) && io.out_ready) begin
            state <= S_IDLE;
          end
        end
`ifdef ALU_PIPE_MUL_EN
        // One multiplier bit per cycle; the last step writes the result directly.
        S_MUL: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            out_q.value    <= prod_nxt[DATA_WIDTH-1:0];
            out_q.carry    <= |prod_nxt[2*DATA_WIDTH-1:DATA_WIDTH];
            out_q.zero     <= (prod_nxt[DATA_WIDTH-1:0] == '0);
            out_q.negative <= prod_nxt[DATA_WIDTH-1];
            state          <= S_HOLD;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io.out_valid  = (state == S_HOLD);
  assign io.result_out = out_q.value;
  assign io.carry      = out_q.carry;
  assign io.zero       = out_q.zero;
  assign io.negative   = out_q.negative;
`ifdef ALU_PIPE_MUL_EN
  assign io.busy = (state == S_MUL);
`else
  assign io.busy = 1'b0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors feed a scoreboard queue; a negedge monitor pops and compares on each output handshake.
module tb_alu_pipe;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  alu_pipe_if #(.DATA_WIDTH(8), .OPCODE_WIDTH(4)) bus ();

  alu_pipe #(.DATA_WIDTH(8), .OPCODE_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    logic [7:0] res;
    logic       c;
    string      name;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] res;
    logic       c;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [7:0] er, input logic ec, input string nm, input bit push);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.opcode   = op;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        if (push) sb.push_back('{er, ec, nm});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        return;
      end
    end
    tests++;
    fails++;
    $display("FAIL %s_accept: in_ready stayed 0, required 1 within 50 cycles", nm);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: compare on every output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_output: got result %0h, required no output", bus.result_out);
        end else begin
          e = sb.pop_front();
          check({e.name, "_result"}, bus.result_out, e.res);
          check({e.name, "_carry"}, bus.carry, e.c);
          check({e.name, "_zero"}, bus.zero, (e.res == 8'h00));
          check({e.name, "_negative"}, bus.negative, e.res[7]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    time t0;
    vecs = '{
      '{8'h42, 8'h00, 4'h0, 8'h42, 1'b0},
      '{8'hFF, 8'h01, 4'h1, 8'h00, 1'b1},
      '{8'h10, 8'h20, 4'h2, 8'h31, 1'b0},
      '{8'h05, 8'h07, 4'h3, 8'hFE, 1'b1},
      '{8'h10, 8'h05, 4'h4, 8'h0A, 1'b0},
      '{8'hFF, 8'h00, 4'h5, 8'h00, 1'b1},
      '{8'h00, 8'h00, 4'h6, 8'hFF, 1'b1},
      '{8'h11, 8'h5A, 4'h7, 8'h5A, 1'b0},
      '{8'hF0, 8'h0F, 4'h8, 8'hFF, 1'b0},
      '{8'hFF, 8'h0F, 4'h9, 8'hF0, 1'b0},
      '{8'h3F, 8'h0F, 4'hA, 8'h0F, 1'b0},
      '{8'h55, 8'h00, 4'hB, 8'hAA, 1'b0},
      '{8'h81, 8'h00, 4'hC, 8'h02, 1'b1},
      '{8'h81, 8'h00, 4'hD, 8'h40, 1'b1},
      '{8'h81, 8'hFF, 4'hF, 8'h00, 1'b0}
    };
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.opcode    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", bus.result_out, 0);
    check("rst_carry", bus.carry, 0);
    check("rst_zero", bus.zero, 0);
    check("rst_negative", bus.negative, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Every opcode issued back to back: one op per cycle with no bubble.
    t0 = $time;
    foreach (vecs[i])
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].c,
            $sformatf("op%0h", vecs[i].op), 1'b1);
    check("throughput_cycles", 32'(($time - t0) / 10), 15);
    @(posedge clk);
    #1;

    // Backpressure holds the AND result, then a retire and new acceptance overlap.
    bus.out_ready = 1'b0;
    issue(8'h3F, 8'h0F, 4'hA, 8'h0F, 1'b0, "bp_and", 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_out_valid", bus.out_valid, 1);
      check("bp_result", bus.result_out, 8'h0F);
      check("bp_in_ready", bus.in_ready, 0);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    issue(8'h7F, 8'h00, 4'h5, 8'h80, 1'b0, "b2b_inc", 1'b1);
    @(negedge clk);
    check("b2b_no_bubble", bus.out_valid, 1);
    @(posedge clk);
    #1;

`ifdef ALU_PIPE_MUL_EN
    issue(8'h0F, 8'h11, 4'hE, 8'hFF, 1'b0, "mul_0f_11", 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("mul_busy", bus.busy, 1);
      check("mul_in_ready", bus.in_ready, 0);
      check("mul_out_valid", bus.out_valid, 0);
    end
    @(negedge clk);
    check("mul_done_valid", bus.out_valid, 1);
    check("mul_done_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    issue(8'h10, 8'h10, 4'hE, 8'h00, 1'b1, "mul_10_10", 1'b1);

    // Reset during the fourth multiply cycle discards the operation.
    issue(8'h0F, 8'h11, 4'hE, 8'h00, 1'b0, "mul_rst", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mul_rst_out_valid", bus.out_valid, 0);
    check("mul_rst_busy", bus.busy, 0);
    check("mul_rst_result", bus.result_out, 0);
    check("mul_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
`else
    issue(8'h12, 8'h34, 4'hE, 8'h00, 1'b0, "op_e_default", 1'b1);
    @(negedge clk);
    check("op_e_busy", bus.busy, 0);
    @(posedge clk);
    #1;
`endif

    // Reset while a result is held in HOLD drops it.
    bus.out_ready = 1'b0;
    issue(8'h33, 8'h00, 4'h0, 8'h33, 1'b0, "hold_rst", 1'b0);
    @(negedge clk);
    check("hold_rst_pre_valid", bus.out_valid, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("hold_rst_out_valid", bus.out_valid, 0);
    check("hold_rst_result", bus.result_out, 0);
    check("hold_rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    issue(8'h42, 8'h00, 4'h0, 8'h42, 1'b0, "after_rst_pass", 1'b1);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
